// File: rtl/prog_sequencer_if.sv
// Program req/ack handshake between the sequencer (master) and the processor (slave).
interface prog_sequencer_if;
    logic req;
    logic ack;

    modport master (output req, input ack);
    modport slave (input req, output ack);
endinterface

// File: rtl/prog_sequencer.sv
// Runs NPROG programs through the req/ack handshake, measuring each one and flagging hangs.
// Define PROG_SEQ_TOTAL_EN to add the saturating total_cycles accumulator output.
module prog_sequencer #(
    parameter int unsigned NPROG   = 3,
    parameter int unsigned REQ_CYC = 2,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned CW      = 16,
    localparam int unsigned PW     = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    prog_sequencer_if.master      bus,
    output logic [PW-1:0]         prog_id,
    output logic [CW-1:0]         cycles,
    output logic                  cyc_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
`ifdef PROG_SEQ_TOTAL_EN
    ,
    output logic [CW+3:0]         total_cycles
`endif
);

    localparam int unsigned RW = (REQ_CYC > 1) ? $clog2(REQ_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StReq, StArm, StRun, StDone, StErr} state_e;

    state_e        stateQ, stateD;
    logic [RW-1:0] rcntQ, rcntD;
    logic [CW-1:0] cntQ, cntD;
    logic [CW-1:0] cyclesQ, cyclesD;
    logic [PW-1:0] progQ, progD;
    logic          cycValidQ, cycValidD;
    logic          doneQ, doneD;
    logic          errQ, errD;
    logic          launch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= StIdle;
            rcntQ     <= '0;
            cntQ      <= '0;
            cyclesQ   <= '0;
            progQ     <= '0;
            cycValidQ <= 1'b0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            stateQ    <= stateD;
            rcntQ     <= rcntD;
            cntQ      <= cntD;
            cyclesQ   <= cyclesD;
            progQ     <= progD;
            cycValidQ <= cycValidD;
            doneQ     <= doneD;
            errQ      <= errD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        rcntD     = rcntQ;
        cntD      = cntQ;
        cyclesD   = cyclesQ;
        progD     = progQ;
        cycValidD = 1'b0;
        doneD     = doneQ;
        errD      = errQ;
        launch    = 1'b0;
        unique case (stateQ)
            StIdle, StDone, StErr: begin
                if (start) begin
                    launch = 1'b1;
                    stateD = StReq;
                    rcntD  = '0;
                    progD  = '0;
                    doneD  = 1'b0;
                    errD   = 1'b0;
                end
            end
            StReq: begin
                if (rcntQ == RW'(REQ_CYC - 1)) begin
                    stateD = StArm;
                    cntD   = '0;
                end else begin
                    rcntD = rcntQ + 1'b1;
                end
            end
            // A stale ack from the previous program is discarded here.
            StArm: begin
                cntD   = cntQ + 1'b1;
                stateD = StRun;
            end
            StRun: begin
                if (bus.ack) begin
                    cyclesD   = cntQ;
                    cycValidD = 1'b1;
                    if (progQ == PW'(NPROG - 1)) begin
                        stateD = StDone;
                        doneD  = 1'b1;
                    end else begin
                        progD  = progQ + 1'b1;
                        rcntD  = '0;
                        stateD = StReq;
                    end
                end else if (cntQ == CW'(TIMEOUT)) begin
                    stateD = StErr;
                    errD   = 1'b1;
                end else if (cntQ != '1) begin
                    cntD = cntQ + 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign bus.req     = (stateQ == StReq);
    assign busy        = (stateQ == StReq) || (stateQ == StArm) || (stateQ == StRun);
    assign prog_id     = progQ;
    assign cycles      = cyclesQ;
    assign cyc_valid   = cycValidQ;
    assign done        = doneQ;
    assign timeout_err = errQ;

`ifdef PROG_SEQ_TOTAL_EN
    logic [CW+3:0] totalQ;
    logic [CW+4:0] totalSum;

    assign totalSum = {1'b0, totalQ} + {5'b0, cyclesQ};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            totalQ <= '0;
        end else if (launch) begin
            totalQ <= '0;
        end else if (cycValidQ) begin
            totalQ <= totalSum[CW+4] ? '1 : totalSum[CW+3:0];
        end
    end

    assign total_cycles = totalQ;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a latency-driven responder, cyc_valid monitor, req-width monitor.
module tb_prog_sequencer;

    localparam int unsigned NPROG   = 3;
    localparam int unsigned REQ_CYC = 2;
    localparam int unsigned TIMEOUT = 4096;
    localparam int unsigned CW      = 16;

    typedef struct {
        int cyc;
        int pid;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start = 1'b0;
    logic          ackResp = 1'b0;
    logic          ackForce = 1'b0;
    logic [1:0]    prog_id;
    logic [CW-1:0] cycles;
    logic          cyc_valid, busy, done, timeout_err;
`ifdef PROG_SEQ_TOTAL_EN
    logic [CW+3:0] total_cycles;
`endif

    prog_sequencer_if bus ();
    assign bus.ack = ackResp | ackForce;

    prog_sequencer #(
        .NPROG   (NPROG),
        .REQ_CYC (REQ_CYC),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .prog_id     (prog_id),
        .cycles      (cycles),
        .cyc_valid   (cyc_valid),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
`ifdef PROG_SEQ_TOTAL_EN
        ,
        .total_cycles(total_cycles)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   gen = 0;
    int   respLat[$];
    exp_t expQ[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Queue one program's responder latency (0 = never ack) and its expected result.
    task automatic addProg(input int lat, input int idx);
        exp_t e;
        respLat.push_back(lat);
        if (lat > 0) begin
            e.cyc = lat - 1;
            e.pid = (idx < NPROG - 1) ? idx + 1 : idx;
            expQ.push_back(e);
        end
    endtask

    // Responder: ack sampled on the lat-th edge after the edge where req fell.
    initial begin
        logic prev;
        logic fell;
        logic aborted;
        int   g;
        int   lat;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fell = prev && !bus.req;
            prev = bus.req;
            if (fell && reset) begin
                g   = gen;
                lat = (respLat.size() > 0) ? respLat.pop_front() : 0;
                if (lat > 0) begin
                    aborted = 1'b0;
                    for (int i = 1; i < lat; i++) begin
                        @(posedge clk);
                        if (gen != g) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    #1;
                    if (!aborted && gen == g) begin
                        ackResp = 1'b1;
                        @(posedge clk);
                        #1;
                        ackResp = 1'b0;
                    end
                    prev = bus.req;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && cyc_valid) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_cyc_valid", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    chk("cycles", cycles, e.cyc);
                    chk("prog_id_at_valid", prog_id, e.pid);
                end
            end
        end
    end

    initial begin
        int reqRun;
        reqRun = 0;
        forever begin
            @(negedge clk);
            if (!reset) reqRun = 0;
            else if (bus.req) reqRun++;
            else if (reqRun > 0) begin
                chk("req_width", reqRun, REQ_CYC);
                reqRun = 0;
            end
        end
    end

    // Pulse start; returns #1 after the edge that sampled it.
    task automatic startSeq();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("req_after_start", bus.req, 1);
        chk("busy_after_start", busy, 1);
        chk("prog_id_after_start", prog_id, 0);
        chk("done_cleared", done, 0);
        chk("err_cleared", timeout_err, 0);
    endtask

    // Count cycles until done (which=0) or timeout_err (which=1), bounded.
    task automatic waitFor(input int which, input int limit, input int expN, input string name);
        int n;
        n = 0;
        while (((which == 0) ? !done : !timeout_err) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, expN);
    endtask

    task automatic chkIdleOutputs(input string tag);
        chk({tag, "_req"}, bus.req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_prog_id"}, prog_id, 0);
        chk({tag, "_cycles"}, cycles, 0);
        chk({tag, "_cyc_valid"}, cyc_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, timeout_err, 0);
`ifdef PROG_SEQ_TOTAL_EN
        chk({tag, "_total"}, total_cycles, 0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chkIdleOutputs("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Three programs at L=258.
        for (int i = 0; i < 3; i++) addProg(258, i);
        startSeq();
        waitFor(0, 3000, 780, "t1_done_time");
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_prog_id", prog_id, 2);
        chk("t1_err", timeout_err, 0);
`ifdef PROG_SEQ_TOTAL_EN
        @(posedge clk);
        #1 chk("t1_total", total_cycles, 771);
`endif

        // Program 1 never acks.
        addProg(258, 0);
        addProg(0, 1);
        startSeq();
        waitFor(1, 6000, 4359, "t2_err_time");
        chk("t2_err", timeout_err, 1);
        chk("t2_busy", busy, 0);
        chk("t2_done", done, 0);
        chk("t2_prog_id", prog_id, 1);
        chk("t2_cycles", cycles, 257);

        // Stale ack through REQ and ARM of program 0.
        ackForce = 1'b1;
        addProg(10, 0);
        addProg(3, 1);
        addProg(4, 2);
        startSeq();
        repeat (3) @(posedge clk);
        #1 ackForce = 1'b0;
        waitFor(0, 200, 20, "t3_done_time");
        chk("t3_done", done, 1);

        // start during RUN of program 1 is ignored.
        for (int i = 0; i < 3; i++) addProg(20, i);
        startSeq();
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t4_busy_after_ignored_start", busy, 1);
        waitFor(0, 200, 35, "t4_done_time");
        chk("t4_done", done, 1);

        // Asynchronous reset during RUN of program 2.
        addProg(20, 0);
        addProg(20, 1);
        respLat.push_back(500);
        startSeq();
        repeat (59) @(posedge clk);
        #3;
        reset = 1'b0;
        gen++;
        respLat.delete();
        #1;
        chkIdleOutputs("t5_async");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("t5_idle_after_release", busy, 0);
        for (int i = 0; i < 3; i++) addProg(5, i);
        startSeq();
        waitFor(0, 200, 21, "t5_done_time");
        chk("t5_done", done, 1);

        // ack in the same cycle cnt hits TIMEOUT.
        addProg(4097, 0);
        addProg(2, 1);
        addProg(3, 2);
        startSeq();
        waitFor(0, 6000, 4108, "t6_done_time");
        chk("t6_done", done, 1);
        chk("t6_err", timeout_err, 0);
`ifdef PROG_SEQ_TOTAL_EN
        @(posedge clk);
        #1 chk("t6_total", total_cycles, 4099);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Initiator side of the program req/ack handshake. It sequences a fixed number of programs through the processor top level: raise `req`, wait for `ack`, record the per-program cycle count, then advance. It replaces the hand-driven bench stimulus so the same sequencing can run in synthesized demo hardware, and it flags a hung program with a timeout.

## Interface
- `NPROG`, 3: number of programs to run per sequence (≥1)
- `REQ_CYC`, 2: cycles `req` is held high per program (≥1)
- `TIMEOUT`, 4096: maximum `cnt` value tolerated in RUN before error (< 2^CW)
- `CW`, 16: cycle-counter width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begin a sequence at program 0
- `ack`  in  1  from processor: current program done
- `req`  out  1  to processor: start next program
- `prog_id`  out  $clog2(NPROG) (min 1)  index of current/last program
- `cycles`  out  CW  measured cycle count of last completed program
- `cyc_valid`  out  1  one-cycle pulse when `cycles` updates
- `busy`  out  1  high in REQ/ARM/RUN
- `done`  out  1  sticky; all NPROG programs acked
- `timeout_err`  out  1  sticky; a program exceeded TIMEOUT

## Operation
- States: IDLE, REQ, ARM, RUN, DONE, ERR. Reset → IDLE; all outputs 0.
- IDLE: `start`=1 → REQ; `prog_id`←0, `done`←0, `timeout_err`←0.
- REQ: `req`=1; `rcnt` counts 0..REQ_CYC-1; at REQ_CYC-1 → ARM, `cnt`←0.
- ARM: one cycle, `ack` ignored (stale ack is discarded); `cnt`++ → RUN.
- RUN: `ack`=1 → `cycles`←`cnt`, `cyc_valid`=1 next cycle; if `prog_id`==NPROG-1 → DONE, else `prog_id`++ and → REQ. Otherwise, if `cnt`==TIMEOUT → ERR. Otherwise `cnt`++ (saturates at 2^CW-1).
- DONE: `done`=1, `busy`=0, `prog_id` holds NPROG-1. `start` → restart as from IDLE.
- ERR: `timeout_err`=1, `busy`=0, `prog_id` holds the failing index, `cycles` unchanged. `start` → restart.
- `start` while `busy` is ignored.
- `ack` and the TIMEOUT match in the same RUN cycle: ack wins, with no error.
- `ack` high outside ARM/RUN is ignored.
- `prog_id` increment never wraps. Terminal index is NPROG-1.

## Timing
- `req` rises on the first edge after `start` is sampled and stays high exactly REQ_CYC cycles.
- `cnt` measures the edges from the first ARM cycle to the edge sampling `ack`. A responder asserting ack L cycles after `req` falls (L≥2) yields `cycles`=L-1.
- `cyc_valid` and the updated `cycles` appear 1 cycle after `ack` is sampled. The next `req` rises on that same edge.
- `reset` low mid-sequence forces IDLE and zeros all outputs immediately, without waiting for a clock. Sequencing resumes only on a new `start` after release.

## Configuration
- `PROG_SEQ_TOTAL_EN` defined: adds output `total_cycles` [CW+3:0]. It is cleared on `start` or reset and accumulates each `cycles` value on `cyc_valid`, without wrapping (saturates).
- Macro undefined: the port and the accumulator are absent, and behaviour is otherwise identical.

## Test plan
- NPROG=3, responder L=258 each: `start` → three `req` pulses of 2 cycles, three `cyc_valid` with `cycles`=257, `prog_id` 0→1→2, then `done`=1 and `busy`=0. With the macro, `total_cycles`=771.
- Responder never acks program 1, TIMEOUT=4096 → ERR after `cnt` reaches 4096. `timeout_err`=1, `prog_id`=1, `cycles`=257 (from program 0).
- Stale `ack` held high through REQ and ARM, then dropped, then raised at L=10 → a single `cyc_valid` with `cycles`=9.
- `start` pulsed during RUN of program 1 → ignored; the sequence completes normally, `done`=1.
- `reset` low during RUN of program 2 → all outputs 0 asynchronously. After release, `start` → runs from `prog_id`=0.
- `ack` asserted in the cycle `cnt`==TIMEOUT → `cyc_valid`=1 with `cycles`=4096 and `timeout_err`=0.
